// File: rtl/ocp_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one OCP slave port among N_MASTERS masters,
// with RDEX/RDL bus locking and a response timeout.
module ocp_arbiter #(
   parameter int N_MASTERS = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT   = 255
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [N_MASTERS*3-1:0]              m_MCmd,
   input  logic [N_MASTERS*ADDR_W-1:0]         m_MAddr,
   input  logic [N_MASTERS*DATA_W-1:0]         m_MData,
   input  logic [N_MASTERS*(DATA_W/8)-1:0]     m_MByteEn,
   output logic [N_MASTERS-1:0]                m_SCmdAccept,
   output logic [N_MASTERS*2-1:0]              m_SResp,
   output logic [DATA_W-1:0]                   m_SData,
   output logic [2:0]                          s_MCmd,
   output logic [ADDR_W-1:0]                   s_MAddr,
   output logic [DATA_W-1:0]                   s_MData,
   output logic [DATA_W/8-1:0]                 s_MByteEn,
   input  logic                                s_SCmdAccept,
   input  logic [1:0]                          s_SResp,
   input  logic [DATA_W-1:0]                   s_SData,
   output logic [N_MASTERS-1:0]                grant
);

   localparam int BE_W = DATA_W / 8;
   localparam int IW   = $clog2(N_MASTERS);
   localparam int CW   = $clog2(TIMEOUT + 2);

   localparam logic [2:0] CMD_IDLE = 3'd0;
   localparam logic [2:0] CMD_WR   = 3'd1;
   localparam logic [2:0] CMD_RDEX = 3'd3;
   localparam logic [2:0] CMD_RDL  = 3'd4;
   localparam logic [2:0] CMD_WRNP = 3'd5;
   localparam logic [2:0] CMD_WRC  = 3'd6;
   localparam logic [2:0] CMD_BCST = 3'd7;

   localparam logic [1:0] RESP_NULL = 2'd0;
   localparam logic [1:0] RESP_FAIL = 2'd2;
   localparam logic [1:0] RESP_ERR  = 2'd3;

   typedef enum logic [1:0] {ARB, CMD, RESP} state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     owner_q, owner_d;
   logic [IW-1:0]     last_q, last_d;
   logic              lock_q, lock_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic [N_MASTERS-1:0] req;
   logic [2:0]           g_cmd;
   logic [IW-1:0]        pick;
   logic                 pick_found;
   int unsigned          rr_idx;
   logic                 acc_fire;
   logic                 resp_fire;
   logic [1:0]           resp_val;

   always_comb begin
      for (int unsigned i = 0; i < N_MASTERS; i++)
         req[i] = (m_MCmd[3*i +: 3] != CMD_IDLE);
   end

   // Slave-side request fields always follow the current owner; only MCmd is qualified.
   always_comb begin
      g_cmd     = CMD_IDLE;
      s_MAddr   = '0;
      s_MData   = '0;
      s_MByteEn = '0;
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
         if (owner_q == IW'(i)) begin
            g_cmd     = m_MCmd[3*i +: 3];
            s_MAddr   = m_MAddr[ADDR_W*i +: ADDR_W];
            s_MData   = m_MData[DATA_W*i +: DATA_W];
            s_MByteEn = m_MByteEn[BE_W*i +: BE_W];
         end
      end
   end

   always_comb begin
      pick       = '0;
      pick_found = 1'b0;
      rr_idx     = 0;
      for (int unsigned k = 1; k <= N_MASTERS; k++) begin
         rr_idx = (32'(last_q) + k) % N_MASTERS;
         if (!pick_found && req[IW'(rr_idx)]) begin
            pick_found = 1'b1;
            pick       = IW'(rr_idx);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      lock_d    = lock_q;
      cnt_d     = cnt_q;
      s_MCmd    = CMD_IDLE;
      acc_fire  = 1'b0;
      resp_fire = 1'b0;
      resp_val  = RESP_NULL;
      unique case (state_q)
         ARB: begin
            if (lock_q) begin
               if (req[owner_q]) state_d = CMD;
            end else if (pick_found) begin
               owner_d = pick;
               last_d  = pick;
               state_d = CMD;
            end
         end
         CMD: begin
            s_MCmd = g_cmd;
            if (g_cmd == CMD_IDLE) begin
               state_d = ARB;
            end else if (s_SCmdAccept) begin
               acc_fire = 1'b1;
               if (g_cmd == CMD_RDEX || g_cmd == CMD_RDL)
                  lock_d = 1'b1;
               else if (g_cmd == CMD_WR || g_cmd == CMD_WRNP || g_cmd == CMD_WRC)
                  lock_d = 1'b0;
               if (g_cmd == CMD_WR || g_cmd == CMD_BCST) begin
                  state_d = ARB;
               end else begin
                  state_d = RESP;
                  cnt_d   = '0;
               end
            end
         end
         RESP: begin
            if (s_SResp != RESP_NULL) begin
               resp_fire = 1'b1;
               resp_val  = s_SResp;
               if (s_SResp == RESP_FAIL || s_SResp == RESP_ERR) lock_d = 1'b0;
               state_d = ARB;
            end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
               resp_fire = 1'b1;
               resp_val  = RESP_ERR;
               lock_d    = 1'b0;
               state_d   = ARB;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = ARB;
      endcase
      // Outputs are silenced combinationally in the reset cycle itself.
      if (reset) begin
         s_MCmd    = CMD_IDLE;
         acc_fire  = 1'b0;
         resp_fire = 1'b0;
      end
   end

   always_comb begin
      m_SCmdAccept = '0;
      m_SResp      = '0;
      grant        = '0;
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
         if (owner_q == IW'(i)) begin
            m_SCmdAccept[i] = acc_fire;
            if (resp_fire) m_SResp[2*i +: 2] = resp_val;
            if (state_q != ARB && !reset) grant[i] = 1'b1;
         end
      end
   end

   assign m_SData = s_SData;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ARB;
         owner_q <= '0;
         last_q  <= IW'(N_MASTERS - 1);
         lock_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         lock_q  <= lock_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_ocp_arbiter.sv
`timescale 1ns/1ps
// Bench for ocp_arbiter: queued master agents, a configurable slave, and a
// transaction-level reference model compared against the DUT every cycle.
module tb_ocp_arbiter;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int TO = 4;

   localparam logic [2:0] IDLE = 3'd0, WR = 3'd1, RD = 3'd2, RDEX = 3'd3,
                          RDL = 3'd4, WRNP = 3'd5, WRC = 3'd6, BCST = 3'd7;
   localparam logic [1:0] NUL = 2'd0, DVA = 2'd1, FAILR = 2'd2, ERR = 2'd3;

   logic             clk = 1'b0;
   logic             reset;
   logic [N*3-1:0]   m_MCmd;
   logic [N*AW-1:0]  m_MAddr;
   logic [N*DW-1:0]  m_MData;
   logic [N*BW-1:0]  m_MByteEn;
   logic [N-1:0]     m_SCmdAccept;
   logic [N*2-1:0]   m_SResp;
   logic [DW-1:0]    m_SData;
   logic [2:0]       s_MCmd;
   logic [AW-1:0]    s_MAddr;
   logic [DW-1:0]    s_MData;
   logic [BW-1:0]    s_MByteEn;
   logic             s_SCmdAccept;
   logic [1:0]       s_SResp;
   logic [DW-1:0]    s_SData;
   logic [N-1:0]     grant;

   ocp_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .m_MCmd(m_MCmd), .m_MAddr(m_MAddr), .m_MData(m_MData), .m_MByteEn(m_MByteEn),
      .m_SCmdAccept(m_SCmdAccept), .m_SResp(m_SResp), .m_SData(m_SData),
      .s_MCmd(s_MCmd), .s_MAddr(s_MAddr), .s_MData(s_MData), .s_MByteEn(s_MByteEn),
      .s_SCmdAccept(s_SCmdAccept), .s_SResp(s_SResp), .s_SData(s_SData),
      .grant(grant)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- master agents ----------------
   logic [2:0] cur [N];
   logic [2:0] mq [N][$];
   bit         abort_m [N];
   int         seqn [N];
   logic [N-1:0] acc_seen;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         m_MCmd[3*i +: 3]     = cur[i];
         m_MAddr[AW*i +: AW]  = 32'hA000_0000 + 32'(i << 8) + 32'(seqn[i]);
         m_MData[DW*i +: DW]  = 32'h1111_1111 * 32'(i + 1) + 32'(seqn[i]);
         m_MByteEn[BW*i +: BW] = BW'(15 >> i);
      end
   end

   always begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
         if (abort_m[i]) begin
            cur[i] = IDLE;
            mq[i].delete();
            abort_m[i] = 1'b0;
         end else if (acc_seen[i] || cur[i] == IDLE) begin
            if (mq[i].size() > 0) begin
               cur[i] = mq[i].pop_front();
               seqn[i]++;
            end else begin
               cur[i] = IDLE;
            end
         end
      end
   end

   // ---------------- slave ----------------
   int         acc_wait = 0;
   int         resp_lat = 2;
   logic [1:0] resp_code = DVA;
   int         rcnt = 0;
   int         cmd_cyc = 0;
   bit         sl_acc = 1'b0;
   logic [2:0] sl_cmd = IDLE;

   always @(negedge clk) begin
      sl_acc = (s_MCmd != IDLE) && s_SCmdAccept && !reset;
      sl_cmd = s_MCmd;
   end

   always begin
      @(posedge clk); #2;
      s_SData = $urandom;
      if (reset) begin
         rcnt = 0; cmd_cyc = 0; s_SCmdAccept = 1'b0; s_SResp = NUL;
      end else begin
         if (sl_acc && !(sl_cmd == WR || sl_cmd == BCST)) rcnt = resp_lat;
         s_SResp = NUL;
         if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) s_SResp = resp_code;
         end
         if (s_MCmd != IDLE) begin
            s_SCmdAccept = (cmd_cyc >= acc_wait);
            cmd_cyc++;
         end else begin
            s_SCmdAccept = 1'b0;
            cmd_cyc = 0;
         end
      end
   end

   // ---------------- reference model + compare ----------------
   int mo_own = -1, mo_last = N - 1, mo_lock = -1, mo_wait = 0;
   bit mo_resp = 1'b0;
   int g;
   logic [N-1:0]   eg, ea;
   logic [N*2-1:0] er;
   logic [2:0]     ec, c;
   logic [N-1:0]   prev_grant = '0;

   int dva_cnt [N], err_cnt [N], fail_cnt [N], acc_cnt [N];
   int cmd_run = 0, acc_run = 0, acc_cyc = 0, err_cyc = 0;
   int gseq [$];

   function automatic logic [2:0] mc(input int i);
      return m_MCmd[3*i +: 3];
   endfunction

   always @(negedge clk) begin
      cyc++;
      acc_seen = m_SCmdAccept;
      eg = '0; ea = '0; er = '0; ec = IDLE;
      g = mo_own;
      if (reset) begin
         mo_own = -1; mo_resp = 1'b0; mo_lock = -1; mo_last = N - 1; mo_wait = 0;
      end else if (mo_own < 0) begin
         if (mo_lock >= 0) begin
            if (mc(mo_lock) != IDLE) mo_own = mo_lock;
         end else begin
            for (int k = 1; k <= N; k++)
               if (mo_own < 0 && mc((mo_last + k) % N) != IDLE) begin
                  mo_own = (mo_last + k) % N;
                  mo_last = mo_own;
               end
         end
      end else if (!mo_resp) begin
         eg = N'(1) << g;
         c  = mc(g);
         ec = c;
         if (c == IDLE) begin
            mo_own = -1;
         end else if (s_SCmdAccept) begin
            ea = N'(1) << g;
            if (c == RDEX || c == RDL) mo_lock = g;
            else if (mo_lock == g && (c == WR || c == WRNP || c == WRC)) mo_lock = -1;
            if (c == WR || c == BCST) mo_own = -1;
            else begin mo_resp = 1'b1; mo_wait = 0; end
         end
      end else begin
         eg = N'(1) << g;
         if (s_SResp != NUL) begin
            er = (2*N)'(s_SResp) << (2*g);
            if (s_SResp == FAILR || s_SResp == ERR) mo_lock = -1;
            mo_own = -1; mo_resp = 1'b0;
         end else begin
            mo_wait++;
            if (mo_wait == TO) begin
               er = (2*N)'(ERR) << (2*g);
               mo_lock = -1; mo_own = -1; mo_resp = 1'b0;
            end
         end
      end

      check("grant", grant, eg);
      check("s_MCmd", s_MCmd, ec);
      check("m_SCmdAccept", m_SCmdAccept, ea);
      check("m_SResp", m_SResp, er);
      check("m_SData", m_SData, s_SData);
      if (ec != IDLE) begin
         check("s_MAddr", s_MAddr, m_MAddr[AW*g +: AW]);
         check("s_MData", s_MData, m_MData[DW*g +: DW]);
         check("s_MByteEn", s_MByteEn, m_MByteEn[BW*g +: BW]);
      end

      if (s_MCmd != IDLE) cmd_run++; else cmd_run = 0;
      for (int i = 0; i < N; i++) begin
         if (m_SCmdAccept[i]) begin acc_cnt[i]++; acc_run = cmd_run; acc_cyc = cyc; end
         if (m_SResp[2*i +: 2] == DVA) dva_cnt[i]++;
         if (m_SResp[2*i +: 2] == FAILR) fail_cnt[i]++;
         if (m_SResp[2*i +: 2] == ERR) begin err_cnt[i]++; err_cyc = cyc; end
         if (grant[i] && prev_grant == '0) gseq.push_back(i);
      end
      prev_grant = grant;
   end

   // ---------------- helpers ----------------
   task automatic clear_stats();
      for (int i = 0; i < N; i++) begin
         dva_cnt[i] = 0; err_cnt[i] = 0; fail_cnt[i] = 0; acc_cnt[i] = 0;
      end
      gseq.delete();
      acc_run = 0; acc_cyc = 0; err_cyc = 0;
   endtask

   function automatic bit all_idle();
      bit r = (mo_own < 0) && (rcnt == 0);
      for (int i = 0; i < N; i++)
         if (cur[i] != IDLE || mq[i].size() != 0) r = 1'b0;
      return r;
   endfunction

   task automatic wait_quiet(input string name);
      int q = 0;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk); #1;
         if (all_idle()) q++; else q = 0;
         if (q >= 3) return;
      end
      check({name, "_timeout"}, 1, 0);
   endtask

   function automatic int gs(input int i);
      return (gseq.size() > i) ? gseq[i] : -1;
   endfunction

   function automatic int total_resp();
      int s = 0;
      for (int i = 0; i < N; i++) s += dva_cnt[i] + err_cnt[i] + fail_cnt[i];
      return s;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      bit ok;
      for (int i = 0; i < N; i++) begin cur[i] = IDLE; abort_m[i] = 1'b0; seqn[i] = 0; end
      s_SCmdAccept = 1'b0; s_SResp = NUL; s_SData = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk); #1;
      check("reset_grant", grant, 0);
      check("reset_s_MCmd", s_MCmd, IDLE);
      check("reset_m_SResp", m_SResp, 0);

      // four simultaneous reads: round robin from master 0
      clear_stats();
      for (int i = 0; i < N; i++) mq[i].push_back(RD);
      wait_quiet("rr4");
      check("rr4_count", gseq.size(), 4);
      for (int i = 0; i < N; i++) begin
         check("rr4_order", gs(i), i);
         check("rr4_dva", dva_cnt[i], 1);
      end

      // delayed accept on a posted write
      clear_stats();
      acc_wait = 3;
      mq[2].push_back(WR);
      wait_quiet("wr_delay");
      check("wr_delay_acc", acc_cnt[2], 1);
      check("wr_delay_cmdcyc", acc_run, 4);
      check("wr_delay_noresp", total_resp(), 0);
      acc_wait = 0;

      // lock: RDEX by master 1 keeps the bus until its WRC
      clear_stats();
      mq[1].push_back(RDEX);
      mq[1].push_back(WRC);
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk); #1;
         if (acc_cnt[1] >= 1) ok = 1'b1;
      end
      check("lock_rdex_accept", ok, 1);
      mq[0].push_back(RD);
      wait_quiet("lock");
      check("lock_count", gseq.size(), 3);
      check("lock_g0", gs(0), 1);
      check("lock_g1", gs(1), 1);
      check("lock_g2", gs(2), 0);

      // response timeout, late DVA dropped
      clear_stats();
      resp_lat = 7;
      mq[3].push_back(RD);
      wait_quiet("timeout");
      check("timeout_err", err_cnt[3], 1);
      check("timeout_delay", err_cyc - acc_cyc, 4);
      check("timeout_stray", dva_cnt[3], 0);
      resp_lat = 2;

      // FAIL response on WRNP
      clear_stats();
      resp_code = FAILR;
      mq[1].push_back(WRNP);
      wait_quiet("fail");
      check("fail_m1", fail_cnt[1], 1);
      check("fail_total", total_resp(), 1);
      resp_code = DVA;

      // master withdraws its command before accept
      clear_stats();
      acc_wait = 100;
      mq[3].push_back(WR);
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk); #1;
         if (grant[3]) ok = 1'b1;
      end
      check("abort_granted", ok, 1);
      abort_m[3] = 1'b1;
      wait_quiet("abort");
      check("abort_acc", acc_cnt[3], 0);
      check("abort_resp", total_resp(), 0);
      acc_wait = 0;

      // reset during RESP
      clear_stats();
      resp_lat = 4;
      mq[0].push_back(RD);
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk); #1;
         if (grant[0] && s_MCmd == IDLE) ok = 1'b1;
      end
      check("rst_in_resp", ok, 1);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk); #1;
      check("rst_grant", grant, 0);
      check("rst_sresp", m_SResp, 0);
      check("rst_acc", m_SCmdAccept, 0);
      @(posedge clk); #1 reset = 1'b0;
      resp_lat = 2;
      clear_stats();
      mq[2].push_back(RD);
      mq[0].push_back(RD);
      wait_quiet("rst");
      check("rst_first", gs(0), 0);
      check("rst_second", gs(1), 2);
      check("rst_dva0", dva_cnt[0], 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
